// File: rtl/avalon_mem_pkg.sv
// avalon_mem_pkg: shared types and constants for the Avalon-MM slave memory.
package avalon_mem_pkg;
  typedef enum logic [1:0] {IDLE, STALL, ACK} state_t;
  typedef enum logic [1:0] {NONE, DECODE, RDWR, DROP} fault_t;
  localparam logic [31:0] DEFAULT_RESET_BASE = 32'hBFC00000;
  // Fibonacci taps 16,14,13,11 mapped onto bits 15,13,12,10
  localparam logic [15:0] LFSR_TAPS = 16'hB400;
  function automatic logic [15:0] lfsr_next(input logic [15:0] s);
    return {s[14:0], ^(s & LFSR_TAPS)};
  endfunction
endpackage

// File: rtl/avalon_mem_slave_stall_lfsr.sv
// stall_lfsr: free-running 16-bit Fibonacci LFSR feeding the random stall length.
module stall_lfsr
  import avalon_mem_pkg::*;
#(
  parameter logic [15:0] SEED = 16'hACE1
) (
  input  logic        clk,
  input  logic        rst,
  output logic [15:0] lfsr_o
);
  logic [15:0] lfsr_q;
  always_ff @(posedge clk or posedge rst)
    if (rst) lfsr_q <= SEED;
    else lfsr_q <= lfsr_next(lfsr_q);
  assign lfsr_o = lfsr_q;
endmodule

// File: rtl/avalon_mem_slave.sv
// avalon_mem_slave: byte-enable Avalon-MM memory with data/reset-vector windows and programmable stalls.
module avalon_mem_slave
  import avalon_mem_pkg::*;
#(
  parameter int          DEPTH_WORDS = 1024,
  parameter logic [31:0] RESET_BASE  = DEFAULT_RESET_BASE,
  parameter int          WAIT_CYCLES = 0,
  parameter int          STALL_MODE  = 0,
  parameter logic [15:0] LFSR_SEED   = 16'hACE1,
  parameter string       INIT_FILE   = ""
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] address,
  input  logic        read,
  input  logic        write,
  input  logic [3:0]  byteenable,
  input  logic [31:0] writedata,
  output logic [31:0] readdata,
  output logic        waitrequest,
  output logic        fault,
  output logic [1:0]  fault_cause
);
  localparam int          AW   = $clog2(DEPTH_WORDS);
  localparam logic [31:0] WIN  = 32'(2 * DEPTH_WORDS);
  localparam logic [4:0]  MODN = 5'(WAIT_CYCLES + 1);
  logic [31:0] mem [DEPTH_WORDS];
  state_t state_q, state_d;
  fault_t cause_q, cause_d;
  logic [3:0] cnt_q, cnt_d, tgt_q, tgt_d, tgt_now;
  logic [31:0] addr_q, off;
  logic rd_q, wr_q, fault_q, req, done, stall, lo, hi, mapped, we;
  logic [AW-1:0] idx;
  logic [15:0] lfsr;
  logic lfsr_unused;
  stall_lfsr #(.SEED(LFSR_SEED)) u_lfsr (.clk(clk), .rst(reset), .lfsr_o(lfsr));
  assign lfsr_unused = ^lfsr[15:4];
  assign tgt_now = (STALL_MODE != 0) ? 4'({1'b0, lfsr[3:0]} % MODN) : 4'(WAIT_CYCLES);
  assign off     = address - RESET_BASE;
  assign lo      = address[1:0] == 2'b00 && address < WIN;
  assign hi      = address[1:0] == 2'b00 && address >= RESET_BASE && off < WIN;
  assign mapped  = lo | hi;
  assign idx     = lo ? {1'b0, address[AW:2]} : {1'b1, off[AW:2]};
  assign req     = read | write;
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    tgt_d   = tgt_q;
    cause_d = NONE;
    done    = 1'b0;
    stall   = 1'b0;
    case (state_q)
      IDLE: if (req) begin
        done    = tgt_now == 4'd0;
        stall   = !done;
        tgt_d   = tgt_now;
        cnt_d   = done ? 4'd0 : 4'd1;
        state_d = done ? IDLE : (tgt_now == 4'd1 ? ACK : STALL);
      end
      STALL: begin
        stall = 1'b1;
        if (!req || address != addr_q || read != rd_q || write != wr_q) begin
          cause_d = DROP;
          state_d = IDLE;
          cnt_d   = 4'd0;
        end else begin
          cnt_d   = cnt_q + 4'd1;
          state_d = cnt_d == tgt_q ? ACK : STALL;
        end
      end
      default: begin
        done    = req;
        state_d = IDLE;
        cnt_d   = 4'd0;
      end
    endcase
    done = done & !reset;
    if (done) cause_d = (read && write) ? RDWR : (!mapped ? DECODE : NONE);
  end
  assign we          = done && write && !read && mapped;
  assign readdata    = (done && read && !write && mapped) ? mem[idx] : 32'h0;
  assign waitrequest = reset | stall;
  assign fault       = fault_q;
  assign fault_cause = cause_q;
  always_ff @(posedge clk or posedge reset)
    if (reset) begin
      state_q <= IDLE;
      cnt_q   <= 4'd0;
      tgt_q   <= 4'd0;
      addr_q  <= 32'h0;
      rd_q    <= 1'b0;
      wr_q    <= 1'b0;
      fault_q <= 1'b0;
      cause_q <= NONE;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      tgt_q   <= tgt_d;
      if (state_q == IDLE) begin
        addr_q <= address;
        rd_q   <= read;
        wr_q   <= write;
      end
      if (!fault_q && cause_d != NONE) begin
        fault_q <= 1'b1;
        cause_q <= cause_d;
      end
    end
  always_ff @(posedge clk)
    if (we)
      for (int i = 0; i < 4; i++)
        if (byteenable[i]) mem[idx][8*i +: 8] <= writedata[8*i +: 8];
endmodule

// File: tb/tb_avalon_mem_slave.sv
// tb_avalon_mem_slave: scoreboard bench over fixed-0, fixed-3 and random-7 stall instances.
module tb_avalon_mem_slave;
  logic clk = 1'b0, rst = 1'b1;
  always #5 clk = ~clk;
  logic [31:0] addr [3], wdat [3], rdat [3];
  logic [3:0]  be [3];
  logic [1:0]  fc [3];
  logic        rd [3], wr [3], wq [3], flt [3];
  typedef struct { int d; logic [31:0] data; } exp_t;
  exp_t sb [$];
  int total = 0, bad = 0, st = 0;
  logic [15:0] m_lfsr;
  logic [7:0] seen = 8'h0;

  avalon_mem_slave #(.WAIT_CYCLES(0)) u0 (.clk(clk), .reset(rst), .address(addr[0]), .read(rd[0]),
    .write(wr[0]), .byteenable(be[0]), .writedata(wdat[0]), .readdata(rdat[0]), .waitrequest(wq[0]),
    .fault(flt[0]), .fault_cause(fc[0]));
  avalon_mem_slave #(.WAIT_CYCLES(3)) u1 (.clk(clk), .reset(rst), .address(addr[1]), .read(rd[1]),
    .write(wr[1]), .byteenable(be[1]), .writedata(wdat[1]), .readdata(rdat[1]), .waitrequest(wq[1]),
    .fault(flt[1]), .fault_cause(fc[1]));
  avalon_mem_slave #(.WAIT_CYCLES(7), .STALL_MODE(1)) u2 (.clk(clk), .reset(rst), .address(addr[2]),
    .read(rd[2]), .write(wr[2]), .byteenable(be[2]), .writedata(wdat[2]), .readdata(rdat[2]),
    .waitrequest(wq[2]), .fault(flt[2]), .fault_cause(fc[2]));

  // reference stall generator: taps 16,14,13,11, reseeded by reset
  always @(posedge clk or posedge rst)
    if (rst) m_lfsr <= 16'hACE1;
    else m_lfsr <= {m_lfsr[14:0], m_lfsr[15] ^ m_lfsr[13] ^ m_lfsr[12] ^ m_lfsr[10]};

  task automatic chk(input string n, input logic [31:0] act, input logic [31:0] want);
    total++;
    if (act !== want) begin
      bad++;
      $display("FAIL %s: got %h want %h", n, act, want);
    end
  endtask

  task automatic clr();
    for (int k = 0; k < 3; k++) begin
      rd[k] = 1'b0;
      wr[k] = 1'b0;
    end
  endtask

  task automatic xfer(input int d, input logic r, input logic w, input logic [31:0] a,
                      input logic [3:0] b, input logic [31:0] wd, input logic [31:0] ex, output int n);
    int want;
    @(posedge clk);
    #1;
    clr();
    rd[d] = r; wr[d] = w; addr[d] = a; be[d] = b; wdat[d] = wd;
    want = d == 0 ? 0 : (d == 1 ? 3 : int'(m_lfsr[2:0]));
    sb.push_back('{d, ex});
    n = 0;
    @(negedge clk);
    while (wq[d] && n < 40) begin
      n++;
      @(negedge clk);
    end
    chk($sformatf("stall_len dut%0d addr %h", d, a), n, want);
  endtask

  task automatic idle();
    @(posedge clk);
    #1;
    clr();
    @(negedge clk);
  endtask

  always @(negedge clk)
    if (!rst)
      for (int d = 0; d < 3; d++)
        if ((rd[d] || wr[d]) && !wq[d]) begin
          exp_t e;
          if (sb.size() == 0) begin
            total++;
            bad++;
            $display("FAIL unexpected_completion dut%0d: got completion want none", d);
          end else begin
            e = sb.pop_front();
            chk($sformatf("dut_id dut%0d", d), d, e.d);
            chk($sformatf("readdata dut%0d addr %h", d, addr[d]), rdat[d], e.data);
          end
        end

  initial begin
    #1000000;
    $display("FAIL watchdog: got no finish want finish");
    $fatal(1);
  end

  initial begin
    for (int k = 0; k < 3; k++) begin
      addr[k] = 32'h0; wdat[k] = 32'h0; be[k] = 4'h0;
    end
    clr();
    repeat (2) @(negedge clk);
    for (int k = 0; k < 3; k++) chk($sformatf("wq_in_reset dut%0d", k), wq[k], 1'b1);
    @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    for (int k = 0; k < 3; k++) begin
      chk($sformatf("wq_after_reset dut%0d", k), wq[k], 1'b0);
      chk($sformatf("rdata_after_reset dut%0d", k), rdat[k], 32'h0);
      chk($sformatf("fault_after_reset dut%0d", k), {fc[k], flt[k]}, 3'b000);
    end
    xfer(0, 0, 1, 32'h190, 4'hF, 32'h0000007B, 32'h0, st);
    xfer(0, 1, 0, 32'h190, 4'h0, 32'h0, 32'h0000007B, st);
    xfer(0, 0, 1, 32'h320, 4'hF, 32'hAABBCCDD, 32'h0, st);
    xfer(0, 0, 1, 32'h320, 4'b0101, 32'h11223344, 32'h0, st);
    xfer(0, 1, 0, 32'h320, 4'h0, 32'h0, 32'hAA22CC44, st);
    xfer(0, 0, 1, 32'h320, 4'h0, 32'hFFFFFFFF, 32'h0, st);
    xfer(0, 1, 0, 32'h320, 4'h0, 32'h0, 32'hAA22CC44, st);
    xfer(0, 0, 1, 32'h7FC, 4'hF, 32'hCAFEF00D, 32'h0, st);
    xfer(0, 1, 0, 32'h7FC, 4'h0, 32'h0, 32'hCAFEF00D, st);
    idle();
    chk("no_fault_clean_traffic", flt[0], 1'b0);
    xfer(1, 0, 1, 32'hBFC00000, 4'hF, 32'h8C010064, 32'h0, st);
    xfer(1, 1, 0, 32'hBFC00000, 4'h0, 32'h0, 32'h8C010064, st);
    xfer(1, 0, 1, 32'hBFC007FC, 4'hF, 32'h12345678, 32'h0, st);
    xfer(1, 1, 0, 32'hBFC007FC, 4'h0, 32'h0, 32'h12345678, st);
    xfer(0, 1, 0, 32'h00000002, 4'h0, 32'h0, 32'h0, st);
    idle();
    chk("misaligned_fault", {fc[0], flt[0]}, 3'b011);
    xfer(0, 1, 1, 32'h190, 4'hF, 32'hDEADBEEF, 32'h0, st);
    idle();
    chk("rdwr_keeps_first_cause", {fc[0], flt[0]}, 3'b011);
    xfer(0, 1, 0, 32'h190, 4'h0, 32'h0, 32'h0000007B, st);
    xfer(2, 1, 0, 32'hBFC00800, 4'h0, 32'h0, 32'h0, st);
    idle();
    chk("window_end_decode_fault", {fc[2], flt[2]}, 3'b011);
    xfer(2, 0, 1, 32'h7FC, 4'hF, 32'h0BADBEEF, 32'h0, st);
    for (int i = 0; i < 200; i++) begin
      xfer(2, 1, 0, 32'h7FC, 4'h0, 32'h0, 32'h0BADBEEF, st);
      seen = seen | 8'(1 << st);
    end
    chk("distinct_stall_lengths_ge4", 32'($countones(seen) >= 4), 32'd1);
    idle();
    @(posedge clk);
    #1 rst = 1'b1;
    @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    chk("fault_cleared_by_reset", {fc[2], flt[2]}, 3'b000);
    @(posedge clk);
    #1;
    rd[1] = 1'b1; addr[1] = 32'h190;
    @(negedge clk);
    chk("drop_wq_stalled", wq[1], 1'b1);
    @(posedge clk);
    #1 rd[1] = 1'b0;
    repeat (2) @(negedge clk);
    chk("drop_fault_cause", {fc[1], flt[1]}, 3'b111);
    chk("drop_wq_idle", wq[1], 1'b0);
    xfer(1, 0, 1, 32'h10, 4'hF, 32'h5555AAAA, 32'h0, st);
    @(posedge clk);
    #1;
    clr();
    wr[1] = 1'b1; addr[1] = 32'h10; wdat[1] = 32'hFFFFFFFF; be[1] = 4'hF;
    @(posedge clk);
    #1 rst = 1'b1;
    @(negedge clk);
    chk("wq_during_midstall_reset", wq[1], 1'b1);
    @(posedge clk);
    #1 wr[1] = 1'b0;
    @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    chk("wq_after_midstall_reset", wq[1], 1'b0);
    chk("rdata_after_midstall_reset", rdat[1], 32'h0);
    xfer(1, 1, 0, 32'h10, 4'h0, 32'h0, 32'h5555AAAA, st);
    idle();
    chk("scoreboard_drained", sb.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
